// File: rtl/seg_pkg.sv
// Shared constants, digit-index type and anode pattern helpers for the
// multiplexed 7-segment scanner.
package seg_pkg;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned NIB_W = 4;

  typedef logic [1:0] idx_t;

  function automatic logic [NDIG-1:0] an_off(input logic pol);
    logic [NDIG-1:0] r;
    r = '1;
    if (pol) r = '0;
    return r;
  endfunction

  function automatic logic [NDIG-1:0] an_on(input idx_t idx, input logic pol);
    logic [NDIG-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return pol ? onehot : ~onehot;
  endfunction

endpackage

// File: rtl/digit_scanner_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while ENA is high and flags the last count.
module tick_gen #(
  parameter int unsigned DIV = 12000
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic ENA,
  output logic TICK
);

  localparam int unsigned   CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign TICK = ENA && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (ENA) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scanner.sv
// Four-digit multiplexed display scanner with frame-synchronous value update.
// Define DIGIT_SCANNER_LZB_EN to enable leading-zero blanking.
module digit_scanner
  import seg_pkg::*;
#(
  parameter int unsigned DIV    = 12000,
  parameter int unsigned AN_POL = 0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        ENA,
  input  logic        LOAD,
  input  logic [15:0] VALUE,
  output logic [3:0]  DIGIT,
  output logic [3:0]  AN,
  output logic        FRAME
);

  localparam logic POL = (AN_POL != 0);

  logic        tick;
  logic        boundary;
  idx_t        idx_q, idx_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  an_q, an_d;
  logic        frame_q, frame_d;
`ifdef DIGIT_SCANNER_LZB_EN
  logic        blank;
`endif

  tick_gen #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RSTN (RSTN),
    .ENA  (ENA),
    .TICK (tick)
  );

  always_comb begin
    boundary = tick && (idx_q == idx_t'(NDIG - 1));
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    frame_d  = boundary;
    if (tick) idx_d = idx_q + idx_t'(1);
    // A LOAD on the boundary tick bypasses the pending stage entirely
    if (boundary) begin
      pend_v_d = 1'b0;
      if (LOAD)          disp_d = VALUE;
      else if (pend_v_q) disp_d = pend_q;
    end else if (LOAD) begin
      pend_d   = VALUE;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
`ifdef DIGIT_SCANNER_LZB_EN
    blank = (idx_q != '0) && ((disp_q >> (NIB_W * idx_q)) == '0);
    an_d  = (!ENA || blank) ? an_off(POL) : an_on(idx_q, POL);
`else
    an_d  = ENA ? an_on(idx_q, POL) : an_off(POL);
`endif
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= an_off(POL);
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign DIGIT = disp_q[NIB_W * idx_q +: NIB_W];
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed self-checking bench for digit_scanner with DIV=4, AN_POL=0.
module tb_digit_scanner;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        ENA = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] VALUE = '0;
  logic [3:0]  DIGIT;
  logic [3:0]  AN;
  logic        FRAME;

  int passed = 0;
  int total  = 0;
  int k      = 0;

  logic [3:0] anpat   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] dig1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] dig9876 [4] = '{4'h6, 4'h7, 4'h8, 4'h9};
  logic [3:0] dig0050 [4] = '{4'h0, 4'h5, 4'h0, 4'h0};

  digit_scanner #(.DIV(4), .AN_POL(0)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .ENA   (ENA),
    .LOAD  (LOAD),
    .VALUE (VALUE),
    .DIGIT (DIGIT),
    .AN    (AN),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic advance_to(input int t);
    while (k < t) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if (DIGIT !== 4'h0) $display("FAIL reset_digit got %h want 0", DIGIT); else passed++;
    total++; if (AN !== 4'hF) $display("FAIL reset_an got %b want 1111", AN); else passed++;
    total++; if (FRAME !== 1'b0) $display("FAIL reset_frame got %b want 0", FRAME); else passed++;
    RSTN = 1'b1;
    ENA  = 1'b1;
    k    = 0;
  endtask

  task automatic test_scan();
    logic f;
    repeat (32) begin
      step();
      f = (k % 16 == 0);
      total++; if (AN !== anpat[((k-1)/4)%4]) $display("FAIL scan_an k=%0d got %b want %b", k, AN, anpat[((k-1)/4)%4]); else passed++;
      total++; if (DIGIT !== 4'h0) $display("FAIL scan_digit k=%0d got %h want 0", k, DIGIT); else passed++;
      total++; if (FRAME !== f) $display("FAIL scan_frame k=%0d got %b want %b", k, FRAME, f); else passed++;
    end
  endtask

  task automatic test_load();
    advance_to(37);
    VALUE = 16'h1234; LOAD = 1'b1;
    step(); LOAD = 1'b0;
    while (k < 48) begin
      total++; if (DIGIT !== 4'h0) $display("FAIL load_hold k=%0d got %h want 0", k, DIGIT); else passed++;
      step();
    end
    while (k < 64) begin
      total++; if (DIGIT !== dig1234[(k/4)%4]) $display("FAIL load_digit k=%0d got %h want %h", k, DIGIT, dig1234[(k/4)%4]); else passed++;
      total++; if (AN !== anpat[((k-1)/4)%4]) $display("FAIL load_an k=%0d got %b want %b", k, AN, anpat[((k-1)/4)%4]); else passed++;
      step();
    end
  endtask

  task automatic test_last_wins();
    advance_to(66);
    VALUE = 16'hAAAA; LOAD = 1'b1; step(); LOAD = 1'b0;
    advance_to(70);
    VALUE = 16'h5555; LOAD = 1'b1; step(); LOAD = 1'b0;
    while (k < 80) begin
      total++; if (DIGIT !== dig1234[(k/4)%4]) $display("FAIL lw_hold k=%0d got %h want %h", k, DIGIT, dig1234[(k/4)%4]); else passed++;
      step();
    end
    while (k < 96) begin
      total++; if (DIGIT !== 4'h5) $display("FAIL lw_digit k=%0d got %h want 5", k, DIGIT); else passed++;
      if (k == 86) begin VALUE = 16'hAAAA; LOAD = 1'b1; end
      if (k == 95) begin VALUE = 16'h9876; LOAD = 1'b1; end
      step();
      LOAD = 1'b0;
    end
    while (k < 128) begin
      total++; if (DIGIT !== dig9876[(k/4)%4]) $display("FAIL bnd_load k=%0d got %h want %h", k, DIGIT, dig9876[(k/4)%4]); else passed++;
      step();
    end
  endtask

  task automatic test_ena_hold();
    advance_to(137);
    ENA = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      total++; if (AN !== 4'hF) $display("FAIL ena_an k=%0d got %b want 1111", k, AN); else passed++;
      total++; if (DIGIT !== 4'h8) $display("FAIL ena_idx k=%0d got %h want 8", k, DIGIT); else passed++;
      if (i == 9) ENA = 1'b1;
      step();
    end
    total++; if (AN !== 4'b1011) $display("FAIL resume_an0 got %b want 1011", AN); else passed++;
    total++; if (DIGIT !== 4'h8) $display("FAIL resume_dig0 got %h want 8", DIGIT); else passed++;
    step(); step();
    total++; if (DIGIT !== 4'h9) $display("FAIL resume_dig2 got %h want 9", DIGIT); else passed++;
    total++; if (AN !== 4'b1011) $display("FAIL resume_an2 got %b want 1011", AN); else passed++;
    step();
    total++; if (AN !== 4'b0111) $display("FAIL resume_an3 got %b want 0111", AN); else passed++;
    advance_to(153);
    total++; if (FRAME !== 1'b0) $display("FAIL resume_nofr got %b want 0", FRAME); else passed++;
    step();
    total++; if (FRAME !== 1'b1) $display("FAIL resume_frame got %b want 1", FRAME); else passed++;
    total++; if (DIGIT !== 4'h6) $display("FAIL resume_wrap got %h want 6", DIGIT); else passed++;
  endtask

  task automatic test_lzb();
    int b;
    int s;
    logic [3:0] e;
    b = k;
    advance_to(b + 1);
    VALUE = 16'h0050; LOAD = 1'b1; step(); LOAD = 1'b0;
    advance_to(b + 16);
    while (k < b + 32) begin
      total++; if (DIGIT !== dig0050[((k-b)/4)%4]) $display("FAIL lzb_digit k=%0d got %h want %h", k, DIGIT, dig0050[((k-b)/4)%4]); else passed++;
      if (k > b + 16) begin
        s = ((k-b-1)/4)%4;
        e = anpat[s];
`ifdef DIGIT_SCANNER_LZB_EN
        if (s >= 2) e = 4'hF;
`endif
        total++; if (AN !== e) $display("FAIL lzb_an0050 k=%0d got %b want %b", k, AN, e); else passed++;
      end
      if (k == b + 18) begin VALUE = 16'h0000; LOAD = 1'b1; end
      step();
      LOAD = 1'b0;
    end
    step();
    while (k < b + 48) begin
      s = ((k-b-1)/4)%4;
      e = anpat[s];
`ifdef DIGIT_SCANNER_LZB_EN
      if (s != 0) e = 4'hF;
`endif
      total++; if (AN !== e) $display("FAIL lzb_an0000 k=%0d got %b want %b", k, AN, e); else passed++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    int b;
    b = k;
    advance_to(b + 2);
    VALUE = 16'hC3C3; LOAD = 1'b1; step(); LOAD = 1'b0;
    advance_to(b + 21);
    VALUE = 16'hBEEF; LOAD = 1'b1; step(); LOAD = 1'b0;
    #2;
    total++; if (DIGIT !== 4'hC) $display("FAIL prerst_digit got %h want c", DIGIT); else passed++;
    RSTN = 1'b0;
    #1;
    total++; if (DIGIT !== 4'h0) $display("FAIL rst_async_digit got %h want 0", DIGIT); else passed++;
    total++; if (AN !== 4'hF) $display("FAIL rst_async_an got %b want 1111", AN); else passed++;
    total++; if (FRAME !== 1'b0) $display("FAIL rst_async_frame got %b want 0", FRAME); else passed++;
    repeat (3) step();
    RSTN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      total++; if (AN !== anpat[((i-1)/4)%4]) $display("FAIL rst_an i=%0d got %b want %b", i, AN, anpat[((i-1)/4)%4]); else passed++;
      total++; if (DIGIT !== 4'h0) $display("FAIL rst_digit i=%0d got %h want 0", i, DIGIT); else passed++;
      total++; if (FRAME !== (i == 16)) $display("FAIL rst_frame i=%0d got %b want %b", i, FRAME, (i == 16)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_ena_hold();
    test_lzb();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
